// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: round-robin arbiter and sequencer that drives a shared 16-bit
// ripple-carry ALU for single-cycle ADD/SUB/AND/OR and a 16-step shift-add
// unsigned multiply that reuses the ALU adder every cycle.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req0_cmd,
  input  logic [1:0]  req1_cmd,
  input  logic [1:0]  req_or,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic        alu_bnegate,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_AND = 2'b10;
  localparam logic [1:0] CMD_MUL = 2'b11;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;

  state_t      state;
  logic        last_grant;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [1:0]  cmd;
  logic        use_or;
  logic        id;
  logic [31:0] prod;
  logic [4:0]  count;

  logic        grant;
  logic        grant_valid;
  logic [1:0]  sel_cmd;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic        sel_or;
  logic [31:0] mul_next;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last
  always_comb begin
    grant       = 1'b0;
    grant_valid = 1'b0;
    case (req_valid)
      2'b01: begin
        grant       = 1'b0;
        grant_valid = 1'b1;
      end
      2'b10: begin
        grant       = 1'b1;
        grant_valid = 1'b1;
      end
      2'b11: begin
        grant       = ~last_grant;
        grant_valid = 1'b1;
      end
      default: begin
        grant       = 1'b0;
        grant_valid = 1'b0;
      end
    endcase
  end

  assign req_ready = (state == IDLE && grant_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign sel_cmd = grant ? req1_cmd : req0_cmd;
  assign sel_a   = grant ? req1_a : req0_a;
  assign sel_b   = grant ? req1_b : req0_b;
  assign sel_or  = grant ? req_or[1] : req_or[0];

  // One shift-add step: the adder carry enters at the top as the product shifts right
  assign mul_next = {alu_cout, alu_result, prod[15:1]};

  // ALU control: latched operands in EXEC, partial-product add in MUL, quiet otherwise
  always_comb begin
    alu_a       = 16'h0000;
    alu_b       = 16'h0000;
    alu_cin     = 1'b0;
    alu_bnegate = 1'b0;
    alu_op      = OP_AND;
    case (state)
      EXEC: begin
        alu_a = op_a;
        alu_b = op_b;
        case (cmd)
          CMD_ADD: alu_op = OP_ADD;
          CMD_SUB: begin
            alu_op      = OP_ADD;
            alu_cin     = 1'b1;
            alu_bnegate = 1'b1;
          end
          CMD_AND: alu_op = use_or ? OP_OR : OP_AND;
          default: alu_op = OP_ADD;
        endcase
      end
      MUL: begin
        alu_a  = prod[31:16];
        alu_b  = prod[0] ? op_a : 16'h0000;
        alu_op = OP_ADD;
      end
      default: begin
        alu_op = OP_AND;
      end
    endcase
  end

  // Sequencer FSM: accept, execute or iterate, then pulse the response for one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= 16'h0000;
      op_b       <= 16'h0000;
      cmd        <= CMD_ADD;
      use_or     <= 1'b0;
      id         <= 1'b0;
      prod       <= 32'h0000_0000;
      count      <= 5'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= 32'h0000_0000;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            cmd        <= sel_cmd;
            use_or     <= sel_or;
            id         <= grant;
            last_grant <= grant;
            prod       <= {16'h0000, sel_b};
            count      <= 5'd0;
            busy       <= 1'b1;
            state      <= (sel_cmd == CMD_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          if (cmd == CMD_AND)
            rsp_data <= {16'h0000, alu_result};
          else
            rsp_data <= {15'h0000, alu_cout, alu_result};
          rsp_valid <= 1'b1;
          rsp_id    <= id;
          state     <= DONE;
        end
        MUL: begin
          prod  <= mul_next;
          count <= count + 5'd1;
          if (count == 5'd15) begin
            rsp_data  <= mul_next;
            rsp_valid <= 1'b1;
            rsp_id    <= id;
            state     <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural model of
// the shared ALU; checks reset state, each operation, latency, arbitration
// order and reset during a multiply.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req0_cmd;
  logic [1:0]  req1_cmd;
  logic [1:0]  req_or;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        busy;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic        alu_bnegate;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_cmd    (req0_cmd),
    .req1_cmd    (req1_cmd),
    .req_or      (req_or),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cin     (alu_cin),
    .alu_bnegate (alu_bnegate),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the shared 16-bit ALU
  logic [16:0] aluSum;
  always_comb begin
    aluSum = {1'b0, alu_a} + {1'b0, (alu_bnegate ? ~alu_b : alu_b)} + {16'h0000, alu_cin};
    alu_cout = aluSum[16];
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = aluSum[15:0];
      default: alu_result = 16'h0000;
    endcase
  end

  // Safety net against a hung simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input int id, input logic [1:0] cmd, input logic orb,
                               input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      req0_cmd  = cmd;
      req0_a    = a;
      req0_b    = b;
      req_or[0] = orb;
      req_valid = 2'b01;
    end else begin
      req1_cmd  = cmd;
      req1_a    = a;
      req1_b    = b;
      req_or[1] = orb;
      req_valid = 2'b10;
    end
    #1;
  endtask

  // Issue one command from an idle negedge and check the full response
  task automatic runOp(input int id, input logic [1:0] cmd, input logic orb,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] expData, input int expLat,
                       input logic [4:0] expCtrl, input string tag);
    int lat;
    int busyCnt;
    logic [4:0] ctrl;
    applyStimulus(id, cmd, orb, a, b);
    checkOutput({tag, " ready"}, {30'h0, req_ready}, (id == 0) ? 32'h1 : 32'h2);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    lat = 0;
    busyCnt = 0;
    ctrl = 5'h1f;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busyCnt++;
      if (lat == 1) ctrl = {alu_op, alu_cin, alu_bnegate};
    end while (!rsp_valid && lat < 40);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " busy_cycles"}, busyCnt, expLat);
    checkOutput({tag, " alu_ctrl"}, {27'h0, ctrl}, {27'h0, expCtrl});
    checkOutput({tag, " rsp_id"}, {31'h0, rsp_id}, id);
    checkOutput({tag, " rsp_data"}, rsp_data, expData);
    @(negedge clk);
    checkOutput({tag, " rsp_after"}, {30'h0, rsp_valid, busy}, 32'h0);
  endtask

  int grantSeen[4];
  int idSeen[4];
  logic [31:0] dataSeen[4];
  int nGrant;
  int nRsp;
  int bothReady;
  int cyc;
  int strayRsp;

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req0_cmd  = 2'b00;
    req1_cmd  = 2'b00;
    req_or    = 2'b00;
    req0_a    = 16'h0;
    req0_b    = 16'h0;
    req1_a    = 16'h0;
    req1_b    = 16'h0;

    repeat (3) @(negedge clk);
    checkOutput("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    checkOutput("reset rsp_data", rsp_data, 32'h0);
    checkOutput("reset rsp_id", {31'h0, rsp_id}, 32'h0);
    checkOutput("reset alu_ab", {alu_a, alu_b}, 32'h0);
    checkOutput("reset alu_ctrl", {27'h0, alu_op, alu_cin, alu_bnegate}, 32'h0);
    rst_n = 1'b1;

    runOp(0, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 32'h0001_0000, 2, 5'b010_0_0, "add_ffff_1");
    runOp(1, 2'b01, 1'b0, 16'd5, 16'd7, 32'h0000_FFFE, 2, 5'b010_1_1, "sub_5_7");
    runOp(1, 2'b01, 1'b0, 16'd7, 16'd5, 32'h0001_0002, 2, 5'b010_1_1, "sub_7_5");
    runOp(0, 2'b10, 1'b0, 16'hF0F0, 16'h3C3C, 32'h0000_3030, 2, 5'b000_0_0, "and");
    runOp(0, 2'b10, 1'b1, 16'hF0F0, 16'h3C3C, 32'h0000_FCFC, 2, 5'b001_0_0, "or");
    runOp(0, 2'b11, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 5'b010_0_0, "mul_ffff");

    // Fresh pointer, then both requesters held valid continuously
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    req0_cmd  = 2'b11;
    req0_a    = 16'd3;
    req0_b    = 16'd5;
    req1_cmd  = 2'b00;
    req1_a    = 16'd1;
    req1_b    = 16'd2;
    req_or    = 2'b00;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      grantSeen[i] = -1;
      idSeen[i]    = -1;
      dataSeen[i]  = 32'hDEAD_BEEF;
    end
    nGrant = 0;
    nRsp = 0;
    bothReady = 0;
    cyc = 0;
    while (nRsp < 4 && cyc < 200) begin
      if (req_ready == 2'b11) bothReady++;
      else if (req_ready != 2'b00 && nGrant < 4) begin
        grantSeen[nGrant] = req_ready[1] ? 1 : 0;
        nGrant++;
      end
      if (rsp_valid) begin
        idSeen[nRsp]   = rsp_id;
        dataSeen[nRsp] = rsp_data;
        nRsp++;
      end
      if (nRsp < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 2'b00;
    checkOutput("rr both_ready", bothReady, 0);
    checkOutput("rr responses", nRsp, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr grant%0d", i), grantSeen[i], i % 2);
      checkOutput($sformatf("rr id%0d", i), idSeen[i], i % 2);
      checkOutput($sformatf("rr data%0d", i), dataSeen[i], (i % 2 == 0) ? 32'd15 : 32'd3);
    end
    @(negedge clk);

    // Reset arriving at iteration 8 of a multiply
    applyStimulus(0, 2'b11, 1'b0, 16'd3, 16'd5);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    strayRsp = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) strayRsp++;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) strayRsp++;
    end
    checkOutput("midrst no_rsp", strayRsp, 0);
    checkOutput("midrst busy", {31'h0, busy}, 32'h0);
    checkOutput("midrst rsp_data", rsp_data, 32'h0);
    checkOutput("midrst rsp_id", {31'h0, rsp_id}, 32'h0);
    checkOutput("midrst alu_ab", {alu_a, alu_b}, 32'h0);
    checkOutput("midrst alu_ctrl", {27'h0, alu_op, alu_cin, alu_bnegate}, 32'h0);
    rst_n = 1'b1;
    runOp(0, 2'b00, 1'b0, 16'd2, 16'd2, 32'd4, 2, 5'b010_0_0, "add_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer and arbiter in front of the 16-bit ripple-carry ALU. Two requesters share one ALU through a round-robin arbiter. The block issues single-cycle ADD/SUB/AND/OR operations and runs a 16-iteration shift-add unsigned multiply that reuses the ALU adder each cycle. It sits between the requesting units and the ALU instance, and drives every ALU control input.

## Interface

Parameters:
- none (datapath width fixed at 16, product width 32)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester command valid, bit i = requester i
- req_ready  out  2  per-requester accept, one-hot or zero
- req0_cmd / req1_cmd  in  2 each  00 ADD, 01 SUB, 10 AND, 11 MUL (or-with-10 unused: 10 is AND, OR is selected by cmd=10 with req_or=1; see below)
- req_or  in  2  per-requester modifier, 1 turns AND into OR (only meaningful with cmd=10)
- req0_a / req0_b / req1_a / req1_b  in  16 each  operands
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_id  out  1  requester that owns the response
- rsp_data  out  32  result
- busy  out  1  high whenever the FSM is not in IDLE
- alu_a / alu_b  out  16 each  ALU operands
- alu_cin / alu_bnegate  out  1 each  ALU carry-in / B invert
- alu_op  out  3  000 AND, 001 OR, 010 ADD
- alu_result  in  16  ALU result
- alu_cout  in  1  ALU carry-out (bit 15)

## Operation

- The FSM has four states: IDLE, EXEC, MUL, DONE.
- In IDLE, the arbiter picks the granted requester:
  - If exactly one req_valid bit is set, that requester is granted.
  - If both are set, the requester not granted last is chosen.
  - The last-grant pointer resets to 1, so requester 0 wins the first contention.
- req_ready[g] = (state==IDLE) & req_valid[g], combinational. The other bit is 0.
- On accept:
  - Operands, cmd, req_or and id are latched, and the pointer is updated.
  - Next state is EXEC for cmd ≠ 11, otherwise MUL.
- EXEC (one cycle) drives the ALU from the latched operands:
  - ADD: op=010, cin=0, bnegate=0.
  - SUB: op=010, cin=1, bnegate=1.
  - AND: op=000. OR: op=001.
  - Result registers capture {15'b0, alu_cout, alu_result} for ADD/SUB and {16'b0, alu_result} for AND/OR. Next state is DONE.
- MUL uses a 32-bit register P = {hi, lo}, initialised to {16'h0, b} on accept, and a 5-bit counter cleared on accept.
  - Each cycle: alu_a=hi, alu_b = lo[0] ? a : 16'h0, op=010, cin=0, bnegate=0.
  - P is then updated to {alu_cout, alu_result, lo[15:1]} (logical right shift with the carry entering at the top), and the counter increments.
  - After the 16th iteration (counter == 15 at the edge), next state is DONE.
- DONE (one cycle): rsp_valid=1, rsp_id=latched id, rsp_data=result (P for MUL). Next state is IDLE.
- Outside EXEC and MUL, the ALU outputs are driven to a=0, b=0, cin=0, bnegate=0, op=000.
- Only one command is in flight at a time. req_valid is ignored outside IDLE.
- Multiply is unsigned. The overflow-free 32-bit product equals a*b.

## Timing

- Reset values (rst_n low at an edge): state=IDLE, pointer=1, all result and P registers 0, counter 0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, and all ALU outputs at their idle values.
- Reset applies mid-operation with no response emitted. The first command after reset release is accepted in the first IDLE cycle.
- Latency, with the accept edge at cycle T:
  - ADD/SUB/AND/OR: EXEC in T+1, rsp_valid high during T+2. Next accept possible at T+3.
  - MUL: iterations in T+1..T+16, rsp_valid during T+17. Next accept at T+18.
- Throughput: one simple op per 3 cycles; one MUL per 18 cycles.
- busy is high from T+1 through the DONE cycle, inclusive.
- Requesters must hold req_valid and operands until their req_ready is seen high. Deasserting before the grant is legal; no command is lost or duplicated.
- Both requesters valid continuously: grants alternate 0, 1, 0, 1, …

## Test plan

- Reset then req0 ADD a=16'hFFFF, b=16'h0001 -> rsp_valid at T+2, rsp_id=0, rsp_data=32'h0001_0000.
- req1 SUB a=5, b=7 -> rsp_data=32'h0000_FFFE (carry 0). Then SUB a=7, b=5 -> 32'h0001_0002.
- req0 AND a=16'hF0F0, b=16'h3C3C -> 32'h0000_3030. Then OR with req_or=1 on the same operands -> 32'h0000_FCFC.
- req0 MUL a=16'hFFFF, b=16'hFFFF -> rsp_valid exactly at T+17, rsp_data=32'hFFFE_0001, busy high for 17 cycles.
- Both requesters held valid with MUL a=3, b=5 (req0) and ADD a=1, b=2 (req1) -> grant order 0, 1, 0, 1; responses 15 (id 0) and 3 (id 1) alternating, with req_ready never high in the same cycle for both.
- rst_n low at iteration 8 of a MUL -> no rsp_valid pulse, outputs at reset values, and a following ADD 2+2 returns 4 from requester 0.
